// File: rtl/pc_address_unit_pkg.sv
// Shared CPU definitions for the PC/address stage.
// Contains the interrupt/reset vector addresses, the control-bit bundle and the PC byte source selection.
package pc_address_unit_pkg;

    localparam int unsigned PC_BYTE_W = 8;
    localparam int unsigned PC_W      = 2 * PC_BYTE_W;

    typedef enum logic [PC_W-1:0] {
        VEC_NMI   = 16'hFFFA,
        VEC_RESET = 16'hFFFC,
        VEC_IRQ   = 16'hFFFE
    } vector_e;

    typedef struct packed {
        logic adl_pcl;
        logic pcl_pcl;
        logic adh_pch;
        logic pch_pch;
        logic i_pc;
    } pc_ctrl_t;

    typedef struct packed {
        logic adl_abl;
        logic adh_abh;
    } ab_ctrl_t;

    typedef enum logic [1:0] {
        PC_SRC_KEEP,
        PC_SRC_HOLD,
        PC_SRC_BUS
    } pc_src_e;

    // The bus select wins over an explicit hold select.
    function automatic pc_src_e pc_src_sel(input logic sel_bus, input logic sel_hold);
        if (sel_bus)
            return PC_SRC_BUS;
        else if (sel_hold)
            return PC_SRC_HOLD;
        else
            return PC_SRC_KEEP;
    endfunction

endpackage

// File: rtl/pc_address_unit_if.sv
// Router-side bundle for the PC/address stage.
// It carries the ADL/ADH bus values, the PC/AB control strobes and the registered PC and address outputs.
interface pc_address_unit_if;
    import pc_address_unit_pkg::*;

    logic [PC_BYTE_W-1:0] i_bus_adl;
    logic [PC_BYTE_W-1:0] i_bus_adh;
    logic                 i_adl_pcl;
    logic                 i_pcl_pcl;
    logic                 i_adh_pch;
    logic                 i_pch_pch;
    logic                 i_i_pc;
    logic                 i_adl_abl;
    logic                 i_adh_abh;
    logic [PC_BYTE_W-1:0] o_pcl;
    logic [PC_BYTE_W-1:0] o_pch;
    logic [PC_W-1:0]      o_address;
    logic                 o_pc_page_cross;

    modport master (
        output i_bus_adl, i_bus_adh, i_adl_pcl, i_pcl_pcl, i_adh_pch, i_pch_pch,
               i_i_pc, i_adl_abl, i_adh_abh,
        input  o_pcl, o_pch, o_address, o_pc_page_cross
    );

    modport slave (
        input  i_bus_adl, i_bus_adh, i_adl_pcl, i_pcl_pcl, i_adh_pch, i_pch_pch,
               i_i_pc, i_adl_abl, i_adh_abh,
        output o_pcl, o_pch, o_address, o_pc_page_cross
    );
endinterface

// File: rtl/pc_address_unit_pc_byte.sv
// One byte of the program counter.
// The byte selects either the bus value or its held value, then adds a carry-in with an 8-bit wrap and produces a carry-out.
module pc_byte
    import pc_address_unit_pkg::*;
#(
    parameter logic [PC_BYTE_W-1:0] RESET_VAL = '0
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [PC_BYTE_W-1:0] i_bus,
    input  logic                 i_sel_bus,
    input  logic                 i_sel_hold,
    input  logic                 i_carry_in,
    output logic [PC_BYTE_W-1:0] o_value,
    output logic                 o_carry_out
);

    logic [PC_BYTE_W-1:0] value_q;
    logic [PC_BYTE_W-1:0] value_d;
    logic [PC_BYTE_W-1:0] src;

    always_comb begin
        src = value_q;
        case (pc_src_sel(i_sel_bus, i_sel_hold))
            PC_SRC_BUS: src = i_bus;
            default:    src = value_q;
        endcase
        value_d     = src + {{(PC_BYTE_W-1){1'b0}}, i_carry_in};
        o_carry_out = i_carry_in & (src == '1);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            value_q <= RESET_VAL;
        else
            value_q <= value_d;
    end

    assign o_value = value_q;

endmodule

// File: rtl/pc_address_unit.sv
// Program counter and external address bus registers located around the internal bus router.
// The PC is split into two pc_byte instances; the PCL carry-out feeds directly into PCH.
module pc_address_unit
    import pc_address_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC      = VEC_RESET,
    parameter logic [PC_W-1:0] RESET_ADDRESS = VEC_RESET
) (
    input  logic               i_clk,
    input  logic               i_reset,
    pc_address_unit_if.slave   bus
);

    pc_ctrl_t pc_ctrl;
    ab_ctrl_t ab_ctrl;

    logic pcl_carry;
    logic pch_carry_unused;

    logic [PC_BYTE_W-1:0] abl_q, abl_d;
    logic [PC_BYTE_W-1:0] abh_q, abh_d;
    logic                 page_cross_q, page_cross_d;

    assign pc_ctrl = '{adl_pcl: bus.i_adl_pcl, pcl_pcl: bus.i_pcl_pcl,
                       adh_pch: bus.i_adh_pch, pch_pch: bus.i_pch_pch,
                       i_pc: bus.i_i_pc};
    assign ab_ctrl = '{adl_abl: bus.i_adl_abl, adh_abh: bus.i_adh_abh};

    pc_byte #(.RESET_VAL(RESET_PC[PC_BYTE_W-1:0])) u_pcl (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_bus       (bus.i_bus_adl),
        .i_sel_bus   (pc_ctrl.adl_pcl),
        .i_sel_hold  (pc_ctrl.pcl_pcl),
        .i_carry_in  (pc_ctrl.i_pc),
        .o_value     (bus.o_pcl),
        .o_carry_out (pcl_carry)
    );

    // PCH adds the PCL carry even when it is loaded from ADH in the same cycle.
    pc_byte #(.RESET_VAL(RESET_PC[PC_W-1:PC_BYTE_W])) u_pch (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_bus       (bus.i_bus_adh),
        .i_sel_bus   (pc_ctrl.adh_pch),
        .i_sel_hold  (pc_ctrl.pch_pch),
        .i_carry_in  (pcl_carry),
        .o_value     (bus.o_pch),
        .o_carry_out (pch_carry_unused)
    );

    always_comb begin
        abl_d        = ab_ctrl.adl_abl ? bus.i_bus_adl : abl_q;
        abh_d        = ab_ctrl.adh_abh ? bus.i_bus_adh : abh_q;
        page_cross_d = pcl_carry;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            abl_q        <= RESET_ADDRESS[PC_BYTE_W-1:0];
            abh_q        <= RESET_ADDRESS[PC_W-1:PC_BYTE_W];
            page_cross_q <= 1'b0;
        end else begin
            abl_q        <= abl_d;
            abh_q        <= abh_d;
            page_cross_q <= page_cross_d;
        end
    end

    assign bus.o_address       = {abh_q, abl_q};
    assign bus.o_pc_page_cross = page_cross_q;

endmodule

// File: tb/tb_pc_address_unit.sv
// Directed testbench for pc_address_unit.
// Expected values are computed by hand from the PC/address bus behaviour.
module tb_pc_address_unit;

    logic i_clk;
    logic i_reset;
    int   errors;
    int   checks;

    pc_address_unit_if bus ();

    pc_address_unit #(
        .RESET_PC      (16'hFFFC),
        .RESET_ADDRESS (16'hFFFC)
    ) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // c = {adl_pcl, pcl_pcl, adh_pch, pch_pch, i_pc, adl_abl, adh_abh}
    task automatic drive(input logic [7:0] adl, input logic [7:0] adh, input logic [6:0] c);
        bus.i_bus_adl = adl;
        bus.i_bus_adh = adh;
        {bus.i_adl_pcl, bus.i_pcl_pcl, bus.i_adh_pch, bus.i_pch_pch,
         bus.i_i_pc, bus.i_adl_abl, bus.i_adh_abh} = c;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_pc(input string tag, input logic [15:0] pc, input logic pcross);
        check(tag, {bus.o_pch, bus.o_pcl}, pc);
        check({tag, "_xing"}, {15'b0, bus.o_pc_page_cross}, {15'b0, pcross});
    endtask

    task automatic load_pc(input logic [15:0] pc);
        drive(pc[7:0], pc[15:8], 7'b1010000);
        tick();
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        i_reset = 1'b1;
        drive(8'h00, 8'h00, 7'b0000000);
        tick();
        tick();
        check_pc("reset_pc", 16'hFFFC, 1'b0);
        check("reset_addr", bus.o_address, 16'hFFFC);
        #2 i_reset = 1'b0;

        // Address bus: ABL loads alone, then ABH
        drive(8'h80, 8'h55, 7'b0000010);
        tick();
        check("abl_only", bus.o_address, 16'hFF80);
        check_pc("abl_pc_hold", 16'hFFFC, 1'b0);
        drive(8'h11, 8'h00, 7'b0000001);
        tick();
        check("abh_only", bus.o_address, 16'h0080);

        // Jump load with and without increment
        drive(8'h34, 8'h12, 7'b1010000);
        tick();
        check_pc("jump", 16'h1234, 1'b0);
        drive(8'hFF, 8'h12, 7'b1010100);
        tick();
        check_pc("jump_inc", 16'h1300, 1'b1);

        // Sequential fetch
        load_pc(16'h0200);
        check_pc("fetch_load", 16'h0200, 1'b0);
        drive(8'h00, 8'h00, 7'b0101100);
        tick();
        check_pc("fetch1", 16'h0201, 1'b0);
        tick();
        check_pc("fetch2", 16'h0202, 1'b0);
        tick();
        check_pc("fetch3", 16'h0203, 1'b0);

        // Page cross lasts for only one cycle
        load_pc(16'h12FF);
        drive(8'h00, 8'h00, 7'b0101100);
        tick();
        check_pc("page_cross", 16'h1300, 1'b1);
        drive(8'h00, 8'h00, 7'b0101000);
        tick();
        check_pc("page_cross_clr", 16'h1300, 1'b0);

        // Full wrap from 0xFFFF to 0x0000
        load_pc(16'hFFFF);
        drive(8'h00, 8'h00, 7'b0101100);
        tick();
        check_pc("wrap", 16'h0000, 1'b1);

        // ADL wins over PCL hold; PCH keeps its value when no select is active
        drive(8'h5A, 8'h99, 7'b1100000);
        tick();
        check_pc("adl_priority", 16'h005A, 1'b0);
        drive(8'hA5, 8'h99, 7'b0000000);
        for (int unsigned i = 0; i < 5; i++) begin
            tick();
            check_pc($sformatf("idle%0d", i), 16'h005A, 1'b0);
        end
        check("idle_addr", bus.o_address, 16'h0080);

        // PC and AB loaded together see the same bus values
        drive(8'h77, 8'h66, 7'b1010011);
        tick();
        check_pc("shared_bus_pc", 16'h6677, 1'b0);
        check("shared_bus_ab", bus.o_address, 16'h6677);

        // Async reset in the middle of a cycle, while the page cross flag is set
        load_pc(16'h00FF);
        drive(8'h00, 8'h00, 7'b0101100);
        tick();
        check_pc("pre_reset", 16'h0100, 1'b1);
        #2 i_reset = 1'b1;
        #1;
        check_pc("async_reset", 16'hFFFC, 1'b0);
        check("async_reset_addr", bus.o_address, 16'hFFFC);
        tick();
        check_pc("reset_held", 16'hFFFC, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
